arduino_cmd_rx: RTL and testbench

//  UART 8N1 receiver for the Arduino serial link. Recovers command bytes and holds
//  the last good byte on arduino_command[7:0], which feeds the mode FSM (0x00 = Manual,
//  0xFF = Auto). Sits between the FPGA rx pin and mode selection.

---
 rtl/arduino_pkg.sv | 20 ++
 rtl/arduino_cmd_rx_if.sv | 19 +
 rtl/rx_sync_2ff.sv | 22 ++
 rtl/arduino_cmd_rx.sv | 145 ++++++++++++++
 tb/tb_arduino_cmd_rx.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/arduino_pkg.sv
// Shared types and constants for the Arduino serial command receiver and the mode FSM.
package arduino_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam logic [7:0] CMD_MANUAL       = 8'h00;
  localparam logic [7:0] CMD_AUTO         = 8'hFF;
  localparam logic [7:0] IDLE_CMD_DEFAULT = 8'hAA;

  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/arduino_cmd_rx_if.sv
// Serial line plus decoded command outputs of the Arduino command receiver.
interface arduino_cmd_rx_if;
  logic       uart_rx;
  logic [7:0] arduino_command;
  logic       cmd_valid;
  logic       frame_err;
  logic       cmd_unknown;
  logic       rx_busy;

  modport slave (
    input  uart_rx,
    output arduino_command, cmd_valid, frame_err, cmd_unknown, rx_busy
  );

  modport master (
    output uart_rx,
    input  arduino_command, cmd_valid, frame_err, cmd_unknown, rx_busy
  );
endinterface

// File: rtl/rx_sync_2ff.sv
// Two-flop synchroniser for the asynchronous rx pin; resets to the idle-high line level.
module rx_sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/arduino_cmd_rx.sv
// UART 8N1 receiver holding the last accepted Arduino command byte.
// Define CMD_FILTER_EN to accept only CMD_MANUAL/CMD_AUTO and flag other bytes on cmd_unknown.
module arduino_cmd_rx
  import arduino_pkg::*;
#(
  parameter int         CLK_FREQ = 50_000_000,
  parameter int         BAUD     = 115_200,
  parameter logic [7:0] IDLE_CMD = IDLE_CMD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  arduino_cmd_rx_if.slave  rx_bus
);
  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_rate
    $error("arduino_cmd_rx: CLKS_PER_BIT must be at least 4");
  end
  if ((IDLE_CMD == CMD_MANUAL) || (IDLE_CMD == CMD_AUTO)) begin : g_bad_idle
    $error("arduino_cmd_rx: IDLE_CMD must not be a mode-switching command");
  end

  logic             w_rx_s;
  logic             w_accept;
  rx_state_t        r_state,   w_state_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift,   w_shift_nxt;
  logic [7:0]       r_cmd,     w_cmd_nxt;
  logic             r_valid,   w_valid_nxt;
  logic             r_ferr,    w_ferr_nxt;
  logic             r_unk,     w_unk_nxt;

  rx_sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx_bus.uart_rx),
    .o_q   (w_rx_s)
  );

`ifdef CMD_FILTER_EN
  assign w_accept = (r_shift == CMD_MANUAL) || (r_shift == CMD_AUTO);
`else
  assign w_accept = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_cmd     <= IDLE_CMD;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_unk     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_cmd     <= w_cmd_nxt;
      r_valid   <= w_valid_nxt;
      r_ferr    <= w_ferr_nxt;
      r_unk     <= w_unk_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_cmd_nxt     = r_cmd;
    w_valid_nxt   = 1'b0;
    w_ferr_nxt    = 1'b0;
    w_unk_nxt     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_cnt_nxt   = '0;
        end
      end
      // A start bit that is high again at its midpoint is a glitch and is dropped silently.
      START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt     = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = w_rx_s ? IDLE : DATA;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (w_rx_s) begin
            w_state_nxt = IDLE;
            if (w_accept) begin
              w_cmd_nxt   = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_unk_nxt = 1'b1;
            end
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      // A line held low (break) must return high before a new start bit is trusted.
      WAIT_HIGH: begin
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rx_bus.arduino_command = r_cmd;
  assign rx_bus.cmd_valid       = r_valid;
  assign rx_bus.frame_err       = r_ferr;
  assign rx_bus.cmd_unknown     = r_unk;
  assign rx_bus.rx_busy         = (r_state != IDLE);
endmodule

// File: tb/tb_arduino_cmd_rx.sv
// Self-checking bench for arduino_cmd_rx at default rates (434 clocks per bit).
module tb_arduino_cmd_rx;
  localparam int CPB       = 50_000_000 / 115_200;
  localparam int SYNC_LAT  = 2;
  // Cycles from driving the start edge until the commit is visible: sync + half bit + 8 data + stop.
  localparam int PULSE_OFS = 1 + SYNC_LAT + CPB / 2 + 9 * CPB;

  localparam int EV_VALID = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_UNK   = 2;

  typedef struct {
    int unsigned at;
    int          kind;
    logic [7:0]  val;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  arduino_cmd_rx_if rx_if ();

  arduino_cmd_rx dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_bus (rx_if)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t         evq[$];
  logic [7:0]  model_cmd = 8'hAA;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_valid_seen = 0;
  int          n_ferr_seen  = 0;
  int          n_unk_seen   = 0;
  int unsigned first_valid_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison of pulses and held command against the timestamped expectations.
  always @(negedge clk) begin
    logic exp_v, exp_f, exp_u;
    ev_t  ev;
    exp_v = 1'b0;
    exp_f = 1'b0;
    exp_u = 1'b0;
    if (!rst_n) begin
      model_cmd = 8'hAA;
      evq.delete();
    end else begin
      while (evq.size() > 0 && evq[0].at == cyc) begin
        ev = evq.pop_front();
        case (ev.kind)
          EV_VALID: begin exp_v = 1'b1; model_cmd = ev.val; end
          EV_FERR:  exp_f = 1'b1;
          default:  exp_u = 1'b1;
        endcase
      end
    end
    check("cmd_valid",       rx_if.cmd_valid,       exp_v);
    check("frame_err",       rx_if.frame_err,       exp_f);
    check("cmd_unknown",     rx_if.cmd_unknown,     exp_u);
    check("arduino_command", rx_if.arduino_command, model_cmd);
    if (rx_if.cmd_valid === 1'b1) begin
      n_valid_seen++;
      if (first_valid_cyc == 0) first_valid_cyc = cyc;
    end
    if (rx_if.frame_err === 1'b1)   n_ferr_seen++;
    if (rx_if.cmd_unknown === 1'b1) n_unk_seen++;
  end

  task automatic wait_bits(input int nbits);
    rx_if.uart_rx = 1'b1;
    repeat (nbits * CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, output int unsigned t0);
    ev_t ev;
    @(negedge clk);
    t0     = cyc;
    ev.at  = t0 + PULSE_OFS;
    ev.val = b;
    if (!stop_ok) ev.kind = EV_FERR;
`ifdef CMD_FILTER_EN
    else if (b != 8'h00 && b != 8'hFF) ev.kind = EV_UNK;
`endif
    else ev.kind = EV_VALID;
    evq.push_back(ev);
    rx_if.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_if.uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_ok) begin
      rx_if.uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx_if.uart_rx = 1'b0;
      repeat (3 * CPB) @(negedge clk);
      rx_if.uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  initial begin
    int unsigned t0;
    int          v_before;
    rx_if.uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    check("reset command", rx_if.arduino_command, 8'hAA);
    check("reset rx_busy", rx_if.rx_busy, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_bits(1);

    send_frame(8'h00, 1'b1, t0);
    wait_bits(2);
    check("cmd after 0x00", rx_if.arduino_command, 8'h00);
    check("pulses after 0x00", n_valid_seen, 1);
    check("0x00 commit latency", first_valid_cyc - t0, 4126);
    check("idle after 0x00", rx_if.rx_busy, 1'b0);

    send_frame(8'hFF, 1'b1, t0);
    send_frame(8'hA5, 1'b1, t0);
    wait_bits(2);
`ifdef CMD_FILTER_EN
    check("cmd after FF,A5", rx_if.arduino_command, 8'hFF);
    check("pulses after FF,A5", n_valid_seen, 2);
    check("unknown after A5", n_unk_seen, 1);
`else
    check("cmd after FF,A5", rx_if.arduino_command, 8'hA5);
    check("pulses after FF,A5", n_valid_seen, 3);
    check("unknown after A5", n_unk_seen, 0);
`endif

    // Short low glitch on the line: receiver goes busy, then drops back without a pulse.
    v_before = n_valid_seen;
    @(negedge clk);
    rx_if.uart_rx = 1'b0;
    repeat (50) @(negedge clk);
    check("busy during glitch", rx_if.rx_busy, 1'b1);
    repeat (50) @(negedge clk);
    rx_if.uart_rx = 1'b1;
    repeat (200) @(negedge clk);
    check("idle after glitch", rx_if.rx_busy, 1'b0);
    check("no pulse on glitch", n_valid_seen, v_before);
    check("no ferr on glitch", n_ferr_seen, 0);

    send_frame(8'h3C, 1'b0, t0);
    wait_bits(2);
    check("ferr count", n_ferr_seen, 1);
    check("idle after break", rx_if.rx_busy, 1'b0);
    send_frame(8'h00, 1'b1, t0);
    wait_bits(2);
    check("cmd after recovery", rx_if.arduino_command, 8'h00);

    // Reset in the middle of data bit 4 of an 0xFF frame.
    v_before = n_valid_seen;
    @(negedge clk);
    rx_if.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_if.uart_rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
    repeat (CPB / 2) @(negedge clk);
    check("busy before reset", rx_if.rx_busy, 1'b1);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("cmd in reset", rx_if.arduino_command, 8'hAA);
    check("busy in reset", rx_if.rx_busy, 1'b0);
    rx_if.uart_rx = 1'b1;
    #2 rst_n = 1'b1;
    wait_bits(4);
    check("cmd after reset", rx_if.arduino_command, 8'hAA);
    check("no pulse from aborted frame", n_valid_seen, v_before);
    send_frame(8'h00, 1'b1, t0);
    wait_bits(2);
    check("cmd after post-reset 0x00", rx_if.arduino_command, 8'h00);
    check("pulse after post-reset 0x00", n_valid_seen, v_before + 1);
    check("expectations drained", evq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
